// File: rtl/ines_rom_writer_if.sv
// ines_rom_writer_if: ROM byte stream in, cartridge memory write handshake out.
interface ines_rom_writer_if;
  logic [7:0] indata;
  logic indata_valid;
  logic [21:0] mem_addr;
  logic [7:0] mem_din;
  logic mem_write;
  logic mem_ready;
  modport master (input indata, indata_valid, mem_ready, output mem_addr, mem_din, mem_write);
  modport slave (output indata, indata_valid, mem_ready, input mem_addr, mem_din, mem_write);
endinterface

// File: rtl/ines_rom_writer.sv
// ines_rom_writer: parses an iNES image stream and writes PRG/CHR payload to cartridge memory.
module ines_rom_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [21:0] CHR_BASE = 22'h200000,
  parameter int MAX_PRG_BANKS = 128
) (
  input  logic clk,
  input  logic reset,
  ines_rom_writer_if.master bus,
  output logic hdr_valid,
  output logic [7:0] mapper,
  output logic mirroring,
  output logic battery,
  output logic four_screen,
  output logic [7:0] prg_banks,
  output logic [7:0] chr_banks,
  output logic done,
  output logic error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] MAGIC = 32'h1A53454E;
  typedef enum logic [2:0] {S_HEADER, S_TRAINER, S_PRG, S_CHR, S_FLUSH, S_DONE, S_ERROR} state_t;
  state_t state, state_n;
  logic [21:0] cnt, cnt_n, push_addr, prg_len, chr_len;
  logic [7:0] flags6;
  logic [3:0] flags7_hi;
  logic [21:0] fifo_a [FIFO_DEPTH];
  logic [7:0] fifo_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, pop, push, last;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop = bus.mem_write && bus.mem_ready;
  assign bus.mem_write = count != '0;
  assign bus.mem_addr = fifo_a[rd_ptr];
  assign bus.mem_din = fifo_d[rd_ptr];
  assign prg_len = {prg_banks, 14'd0};
  assign chr_len = {1'b0, chr_banks, 13'd0};
  assign push_addr = state == S_CHR ? CHR_BASE + cnt : cnt;
  assign mapper = {flags7_hi, flags6[7:4]};
  assign mirroring = flags6[0];
  assign battery = flags6[1];
  assign four_screen = flags6[3];
  assign done = state == S_DONE;
  assign error = state == S_ERROR;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    push = 1'b0;
    last = 1'b0;
    case (state)
      S_HEADER: if (bus.indata_valid) begin
        cnt_n = cnt + 22'd1;
        if (cnt < 22'd4 && bus.indata != MAGIC[{cnt[1:0], 3'b000} +: 8]) state_n = S_ERROR;
        else if (cnt == 22'd15) begin
          cnt_n = '0;
          state_n = prg_banks == 8'd0 || int'(prg_banks) > MAX_PRG_BANKS ? S_ERROR :
                    flags6[2] ? S_TRAINER : S_PRG;
        end
      end
      S_TRAINER: if (bus.indata_valid) begin
        last = cnt == 22'd511;
        cnt_n = last ? '0 : cnt + 22'd1;
        state_n = last ? S_PRG : S_TRAINER;
      end
      S_PRG, S_CHR: if (bus.indata_valid) begin
        // a full FIFO still takes a byte when its head leaves this same cycle
        if (full && !pop) state_n = S_ERROR;
        else begin
          push = 1'b1;
          last = cnt == (state == S_PRG ? prg_len : chr_len) - 22'd1;
          cnt_n = last ? '0 : cnt + 22'd1;
          state_n = !last ? state : state == S_PRG && chr_banks != 8'd0 ? S_CHR : S_FLUSH;
        end
      end
      S_FLUSH: if (count == '0 || (count == (AW+1)'(1) && pop)) state_n = S_DONE;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_HEADER;
      cnt <= '0;
      hdr_valid <= 1'b0;
      flags6 <= '0;
      flags7_hi <= '0;
      prg_banks <= '0;
      chr_banks <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == S_HEADER && bus.indata_valid) begin
        if (cnt == 22'd4) prg_banks <= bus.indata;
        if (cnt == 22'd5) chr_banks <= bus.indata;
        if (cnt == 22'd6) flags6 <= bus.indata;
        if (cnt == 22'd7) flags7_hi <= bus.indata[7:4];
      end
      if (state == S_HEADER && (state_n == S_TRAINER || state_n == S_PRG)) hdr_valid <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || state_n == S_ERROR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_a[wr_ptr] <= push_addr;
        fifo_d[wr_ptr] <= bus.indata;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_ines_rom_writer.sv
// tb_ines_rom_writer: directed iNES images checked against an address/data write model.
module tb_ines_rom_writer;
  localparam logic [21:0] CHR_BASE = 22'h200000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic hdr_valid, mirroring, battery, four_screen, done, error;
  logic [7:0] mapper, prg_banks, chr_banks;
  int checks = 0, fails = 0, acc_cnt = 0, wr_seen = 0;
  logic [29:0] exp_q[$];
  logic [29:0] first_w, e;
  logic expect_final = 1'b0, chk_done = 1'b0, prev_stall = 1'b0;
  logic [21:0] p_addr;
  logic [7:0] p_din, pseed = 8'h00;

  ines_rom_writer_if bus();
  assign bus.mem_ready = !stall;

  ines_rom_writer #(.FIFO_DEPTH(4), .CHR_BASE(CHR_BASE), .MAX_PRG_BANKS(128)) dut (
    .clk(clk), .reset(reset), .bus(bus), .hdr_valid(hdr_valid), .mapper(mapper),
    .mirroring(mirroring), .battery(battery), .four_screen(four_screen),
    .prg_banks(prg_banks), .chr_banks(chr_banks), .done(done), .error(error)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return i[7:0] ^ i[15:8] ^ pseed;
  endfunction

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.indata = b;
    bus.indata_valid = 1'b1;
    @(posedge clk); #1;
    bus.indata_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_hdr(input logic [7:0] prg, input logic [7:0] chr, input logic [7:0] f6, input logic [7:0] f7);
    logic [7:0] h [16];
    h = '{8'h4E, 8'h45, 8'h53, 8'h1A, prg, chr, f6, f7, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) send(h[i], 0);
  endtask

  task automatic send_image(input logic [7:0] prg, input logic [7:0] chr, input logic [7:0] f6, input logic [7:0] f7);
    int t, plen, clen;
    t = f6[2] ? 512 : 0;
    plen = int'(prg) * 16384;
    clen = int'(chr) * 8192;
    for (int p = 0; p < plen; p++) exp_q.push_back({22'(p), pat(16 + t + p)});
    for (int c = 0; c < clen; c++) exp_q.push_back({CHR_BASE + 22'(c), pat(16 + t + plen + c)});
    expect_final = 1'b1;
    send_hdr(prg, chr, f6, f7);
    for (int i = 16; i < 16 + t + plen + clen; i++) send(pat(i), 0);
  endtask

  task automatic wait_done(input string n);
    int k;
    k = 0;
    while (!done && k < 200) begin @(posedge clk); #1; k++; end
    check(n, 32'(done), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    expect_final = 1'b0;
    acc_cnt = 0;
    wr_seen = 0;
    check("rst_mem_write", 32'(bus.mem_write), 0);
    check("rst_status", {hdr_valid, done, error, mirroring, battery, four_screen}, 0);
    check("rst_fields", {mapper, prg_banks, chr_banks}, 0);
  endtask

  // cycle-by-cycle monitor: write order/content, stall stability, status exclusivity
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_stall = 1'b0;
      chk_done = 1'b0;
    end else begin
      checks++;
      if ((done && error) || (done && exp_q.size() != 0)) begin
        fails++;
        $display("FAIL status: done=%0b error=%0b pending=%0d, need done only with nothing pending", done, error, exp_q.size());
      end
      if (chk_done) begin
        checks++;
        if (done !== 1'b1) begin fails++; $display("FAIL done_latency: got %0b expected 1", done); end
        chk_done = 1'b0;
      end
      if (prev_stall && !error) begin
        checks++;
        if (!(bus.mem_write === 1'b1 && bus.mem_addr === p_addr && bus.mem_din === p_din)) begin
          fails++;
          $display("FAIL stall_hold: got w=%0b a=%0h d=%0h expected w=1 a=%0h d=%0h", bus.mem_write, bus.mem_addr, bus.mem_din, p_addr, p_din);
        end
      end
      if (bus.mem_write) wr_seen++;
      if (bus.mem_write && bus.mem_ready) begin
        checks++;
        if (acc_cnt == 0) first_w = {bus.mem_addr, bus.mem_din};
        acc_cnt++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got a=%0h d=%0h expected no write", bus.mem_addr, bus.mem_din);
        end else begin
          e = exp_q.pop_front();
          if (e !== {bus.mem_addr, bus.mem_din}) begin
            fails++;
            $display("FAIL write: got a=%0h d=%0h expected a=%0h d=%0h", bus.mem_addr, bus.mem_din, e[29:8], e[7:0]);
          end
          if (exp_q.size() == 0 && expect_final) chk_done = 1'b1;
        end
      end
      prev_stall = bus.mem_write && !bus.mem_ready;
      p_addr = bus.mem_addr;
      p_din = bus.mem_din;
    end
  end

  initial begin
    bus.indata = 8'h00;
    bus.indata_valid = 1'b0;
    do_reset();
    // full image: 2 PRG banks, 1 CHR bank, vertical mirroring
    send_image(8'd2, 8'd1, 8'h01, 8'h00);
    wait_done("t1_done");
    check("t1_writes", 32'(acc_cnt), 40960);
    check("t1_first", 32'(first_w), {10'd0, 22'h0, 8'h10});
    check("t1_hdr", {hdr_valid, mirroring, battery, four_screen, error}, 5'b11000);
    check("t1_fields", {mapper, prg_banks, chr_banks}, {8'h00, 8'h02, 8'h01});
    check("t1_pending", 32'(exp_q.size()), 0);
    do_reset();
    // trainer present, mapper 1, no CHR
    send_image(8'd1, 8'd0, 8'h14, 8'h00);
    wait_done("t2_done");
    check("t2_writes", 32'(acc_cnt), 16384);
    check("t2_first", 32'(first_w), {10'd0, 22'h0, 8'h12});
    check("t2_fields", {mapper, prg_banks, chr_banks, 7'(mirroring)}, {8'h01, 8'h01, 8'h00, 7'd0});
    do_reset();
    // bad magic byte 2
    send(8'h4E, 0);
    send(8'h45, 0);
    check("t3_err_early", 32'(error), 0);
    send(8'h54, 0);
    check("t3_err", 32'(error), 1);
    for (int i = 3; i < 36; i++) send(i == 3 ? 8'h1A : i == 4 ? 8'h01 : 8'(i), 0);
    check("t3_nowrite", 32'(wr_seen), 0);
    check("t3_status", {hdr_valid, done, error}, 3'b001);
    do_reset();
    // stall with sparse input, drain, then overflow under a stall
    send_hdr(8'd1, 8'd0, 8'h00, 8'h00);
    stall = 1'b1;
    for (int i = 16; i < 19; i++) begin
      exp_q.push_back({22'(i - 16), pat(i)});
      send(pat(i), 2);
    end
    check("t4_no_err", 32'(error), 0);
    check("t4_head", {bus.mem_write, bus.mem_addr, bus.mem_din}, {1'b1, 22'h0, 8'h10});
    stall = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("t4_drained", {bus.mem_write, 8'(exp_q.size())}, 0);
    stall = 1'b1;
    for (int i = 19; i < 23; i++) send(pat(i), 0);
    check("t4_full", {error, bus.mem_write, bus.mem_addr}, {1'b0, 1'b1, 22'd3});
    send(pat(23), 0);
    check("t4_overflow", {error, bus.mem_write, done}, 3'b100);
    send(pat(24), 0);
    check("t4_ignored", {error, bus.mem_write}, 2'b10);
    stall = 1'b0;
    do_reset();
    // PRG bank count out of range, then zero
    send_hdr(8'h81, 8'd0, 8'h00, 8'h00);
    check("t5_big", {error, hdr_valid}, 2'b10);
    do_reset();
    send_hdr(8'h00, 8'd1, 8'h00, 8'h00);
    check("t5_zero", {error, hdr_valid}, 2'b10);
    do_reset();
    // reset mid-load with stale FIFO contents, then a fresh image
    send_hdr(8'd1, 8'd0, 8'h00, 8'h00);
    for (int i = 16; i < 112; i++) begin
      exp_q.push_back({22'(i - 16), pat(i)});
      send(pat(i), 0);
    end
    repeat (2) begin @(posedge clk); #1; end
    check("t6_written", 32'(exp_q.size()), 0);
    stall = 1'b1;
    for (int i = 112; i < 116; i++) send(pat(i), 0);
    check("t6_stale", {error, bus.mem_write}, 2'b01);
    stall = 1'b0;
    do_reset();
    pseed = 8'h5A;
    send_image(8'd1, 8'd0, 8'h00, 8'h00);
    wait_done("t6_done");
    check("t6_writes", 32'(acc_cnt), 16384);
    check("t6_first", 32'(first_w), {10'd0, 22'h0, 8'h4A});
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end
endmodule
